// File: rtl/reg_pipe_pkg.sv
// Shared defaults and helpers for the stallable register pipeline (reg_pipe_hs).
package reg_pipe_pkg;

  localparam int RP_WD_DEFAULT    = 8;
  localparam int RP_DEPTH_DEFAULT = 4;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One valid+data retiming stage; loads from upstream when it or anything downstream has room.
module reg_pipe_stage #(
  parameter int WD = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [WD-1:0] up_data,
  input  logic          dn_ready,
  output logic          v,
  output logic [WD-1:0] d,
  output logic          rdy
);

  logic          r_v;
  logic [WD-1:0] r_d;
  logic          w_rdy;

  assign w_rdy = ~r_v | dn_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_v <= 1'b0;
    else if (flush)   r_v <= 1'b0;
    else if (w_rdy)   r_v <= up_valid;
  end

  // Data only moves with a real word so bubbles do not toggle the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_d <= '0;
    else if (w_rdy && up_valid)   r_d <= up_data;
  end

  assign v   = r_v;
  assign d   = r_d;
  assign rdy = w_rdy;

endmodule

// File: rtl/reg_pipe_hs.sv
// DEPTH-stage valid/ready register pipeline with occupancy count.
// Optional synchronous flush port when REG_PIPE_FLUSH_EN is defined.
module reg_pipe_hs
  import reg_pipe_pkg::*;
#(
  parameter  int WD    = RP_WD_DEFAULT,
  parameter  int DEPTH = RP_DEPTH_DEFAULT,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
`ifdef REG_PIPE_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] out_data,
  output logic [CW-1:0] count
);

  logic              w_flush;
  logic [DEPTH-1:0]  w_v;
  logic [WD-1:0]     w_d [DEPTH];
  logic [DEPTH:0]    w_rdy;
  logic              w_in_hs;
  logic              w_out_hs;
  logic [CW-1:0]     r_count;

`ifdef REG_PIPE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      reg_pipe_stage #(.WD(WD)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_flush),
        .up_valid (in_valid),
        .up_data  (in_data),
        .dn_ready (w_rdy[i+1]),
        .v        (w_v[i]),
        .d        (w_d[i]),
        .rdy      (w_rdy[i])
      );
    end else begin : g_next
      reg_pipe_stage #(.WD(WD)) u_stage (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_flush),
        .up_valid (w_v[i-1]),
        .up_data  (w_d[i-1]),
        .dn_ready (w_rdy[i+1]),
        .v        (w_v[i]),
        .d        (w_d[i]),
        .rdy      (w_rdy[i])
      );
    end
  end

  // Flush blocks both handshakes so nothing crosses the boundary in that cycle.
  assign in_ready  = w_rdy[0] & ~w_flush;
  assign out_valid = w_v[DEPTH-1] & ~w_flush;
  assign out_data  = w_d[DEPTH-1];

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_count <= '0;
    else if (w_flush)               r_count <= '0;
    else if (w_in_hs && !w_out_hs)  r_count <= r_count + CW'(1);
    else if (!w_in_hs && w_out_hs)  r_count <= r_count - CW'(1);
  end

  assign count = r_count;

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Randomized self-checking bench for reg_pipe_hs against a queue-based word/age model.
module tb_reg_pipe_hs;

  localparam int WD    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [WD-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] out_data;
  logic [2:0]    count;

  always #5 clk = ~clk;

  reg_pipe_hs #(.WD(WD), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef REG_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // A word is at the output once DEPTH-1 edges have passed since capture;
  // the oldest word is never blocked before the last stage.
  typedef struct {
    logic [WD-1:0] d;
    int            age;
  } word_t;

  word_t         m_q[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [WD-1:0] tb_word;
  bit            rand_data;
  int            n_in, n_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic iv, input logic ordy, input logic fl);
    logic e_ir, e_ov, hs_in, hs_out;
    in_valid  = iv;
    in_data   = tb_word;
    out_ready = ordy;
    flush     = fl;
    #1;
    e_ir = !fl && ((m_q.size() < DEPTH) || ordy);
    e_ov = !fl && (m_q.size() > 0) && (m_q[0].age >= DEPTH-1);
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("count", 32'(count), 32'(m_q.size()));
    if (e_ov) chk("out_data", 32'(out_data), 32'(m_q[0].d));
    hs_in  = iv && e_ir;
    hs_out = e_ov && ordy;
    @(posedge clk);
    if (fl) m_q.delete();
    else begin
      if (hs_out) begin void'(m_q.pop_front()); n_out++; end
      foreach (m_q[j]) m_q[j].age++;
      if (hs_in) begin
        m_q.push_back('{d: tb_word, age: 0});
        n_in++;
        tb_word = rand_data ? WD'($urandom) : tb_word + 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tb_word = 8'h01; rand_data = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming 0x01..0x10 with consumer always ready, then drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)  step(1'b0, 1'b1, 1'b0);
    chk("stream_io", 32'(n_out), 32'd16);

    // Backpressure: offer 6 words while stalled, then release
    n_in = 0; n_out = 0; tb_word = 8'h01;
    for (int i = 0; i < 8 && n_in < 6; i++) step(1'b1, 1'b0, 1'b0);
    chk("bp_accepted", 32'(n_in), 32'd4);
    chk("bp_count", 32'(count), 32'd4);
    for (int i = 0; i < 20 && n_out < 6; i++) step(n_in < 6, 1'b1, 1'b0);
    chk("bp_drained", 32'(n_out), 32'd6);

    // Bubble collapse: one word, long stall, then three more
    n_in = 0; tb_word = 8'h21;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 1'b0);
    chk("bubble_count", 32'(count), 32'd4);

    // Simultaneous in/out on a full pipe
    n_in = 0; n_out = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    chk("simul_in", 32'(n_in), 32'd5);
    chk("simul_out", 32'(n_out), 32'd5);
    chk("simul_count", 32'(count), 32'd4);

    // Random traffic
    rand_data = 1'b1;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50), 1'b0);

`ifdef REG_PIPE_FLUSH_EN
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 5));
`endif

    // Reset mid-stream with three words held
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    m_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_pipe_hs.md
# reg_pipe_hs

Parametrised, stallable register pipeline with a valid/ready handshake and async active-high reset. It generalises the team's plain D flip-flop to DEPTH stages of WD-bit data, with per-stage valid tracking, backpressure and an occupancy counter. It sits between producer/consumer blocks wherever timing needs retiming stages that must not drop data under stall.

## Interface
- WD, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  pipeline can accept a word this cycle
- in_data  in  WD  input word
- out_valid  out  1  stage DEPTH-1 holds a valid word
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  WD  output word (stage DEPTH-1 data)
- count  out  CW  number of valid words held, 0..DEPTH
- flush  in  1  synchronous flush (present only with REG_PIPE_FLUSH_EN)

## Operation
- Stage i holds v[i] and d[i]; stage 0 is input side, stage DEPTH-1 drives out_*.
- Stage ready: rdy[DEPTH-1] = ~v[DEPTH-1] | out_ready; rdy[i] = ~v[i] | rdy[i+1]. in_ready = rdy[0].
- Stage i loads from stage i-1 (or input for i=0) when rdy[i]; v[i] takes upstream valid, d[i] takes upstream data only when upstream valid is 1 (no data toggling on bubbles).
- Stage with rdy[i]=0 holds v[i] and d[i] unchanged.
- Input handshake: in_valid & in_ready at a rising edge. Output handshake: out_valid & out_ready.
- count: +1 on input handshake only, -1 on output handshake only, unchanged when both or neither. Never exceeds DEPTH, never underflows.
- Bubbles collapse: a stalled output does not block upstream stages that are empty.
- Reset (async, any time, including mid-transfer): all v[i]=0, all d[i]=0, count=0; hence out_valid=0, out_data=0, in_ready=1 while reset deasserted. In-flight words are discarded.

## Timing
- Latency: word accepted at edge k appears on out_data with out_valid=1 after edge k+DEPTH-1 (i.e. DEPTH edges including capture), with out_ready held 1.
- Throughput: one word per cycle when out_ready=1 continuously.
- Full pipeline (count=DEPTH) with out_ready=0: in_ready=0; in_ready rises combinationally in the same cycle out_ready rises.
- Combinational path out_ready→in_ready spans DEPTH ready terms; acceptable for DEPTH ≤ 8.
- Simultaneous in and out handshake on a full pipeline: both occur, count stays DEPTH.

## Configuration
- REG_PIPE_FLUSH_EN defined: flush port exists. flush=1 at an edge clears all v[i] and sets count=0; in_ready is forced 0 while flush=1 so no input is accepted; out_valid is forced 0 while flush=1 so no output handshake occurs. d[i] contents are not cleared. Reset overrides flush.
- Not defined: no flush port; behaviour as above without flush.

## Structure
- Package reg_pipe_pkg: function for count width (clog2 of DEPTH+1) and a localparam default for WD/DEPTH used by instantiating blocks.
- Sub-module reg_pipe_stage: one valid+data stage with upstream valid/data, downstream ready in, own ready out; top level generates DEPTH instances and the count logic.

## Test plan
- Reset mid-stream: load 3 words (DEPTH=4), assert reset between edges -> out_valid=0, out_data=0, count=0 immediately; in_ready=1 after deassert.
- Streaming: out_ready=1, send 0x01..0x10 back-to-back -> 0x01 on out after 4 edges, then one word per cycle in order, count steady at 4.
- Backpressure: out_ready=0, send 6 words -> 4 accepted (0x01..0x04), in_ready=0, count=4; release out_ready -> 0x01..0x06 out in order, no loss or duplication.
- Bubble collapse: one word in, out_ready=0 for 10 cycles, then send 3 more -> all 4 held, count=4, in_ready=0 only after 4th accepted.
- Simultaneous: full pipe, in_valid=1 and out_ready=1 for 5 cycles -> 5 in, 5 out, count stays 4.
- Flush (REG_PIPE_FLUSH_EN): 3 words held, flush=1 with in_valid=1 -> in_ready=0, out_valid=0, next cycle count=0 and no word from before flush ever appears.
